// File: rtl/dct_coef_serializer.sv
// Ping-pong coefficient buffer for the 8x8 DCT: captures whole blocks, streams them one beat at a time.
// Scan order: zigzag when DCT_SER_ZIGZAG_EN is defined, raster otherwise.
module dct_coef_serializer #(
  parameter int DATA_W = 16,
  parameter int N_DIM  = 8
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [N_DIM*N_DIM*DATA_W-1:0]   blk_in,
  input  logic                            blk_valid,
  output logic                            blk_ready,
  output logic [DATA_W-1:0]               coef_out,
  output logic [5:0]                      coef_idx,
  output logic                            coef_valid,
  input  logic                            coef_ready,
  output logic                            coef_last,
  output logic [15:0]                     drop_cnt
);

  localparam int N_COEF = N_DIM * N_DIM;

  typedef enum logic {IDLE, STREAM} state_t;

  state_t      state_reg, state_next;
  logic [1:0]  full_reg, full_next;
  logic        wr_ptr_reg, wr_ptr_next;
  logic        rd_ptr_reg, rd_ptr_next;
  logic [5:0]  cnt_reg, cnt_next;
  logic [15:0] drop_cnt_reg, drop_cnt_next;

  logic [DATA_W-1:0] bank [2][N_COEF];
  logic [DATA_W-1:0] blk_word [N_COEF];
  logic              capture;
  logic              xfer;
  logic              last_beat;
  logic [5:0]        rd_addr;

  genvar gi;
  generate
    for (gi = 0; gi < N_COEF; gi++) begin : g_unpack
      assign blk_word[gi] = blk_in[gi*DATA_W +: DATA_W];
    end
  endgenerate

`ifdef DCT_SER_ZIGZAG_EN
  localparam logic [5:0] ZZ_TAB [64] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };
  assign rd_addr = ZZ_TAB[cnt_reg];
`else
  assign rd_addr = cnt_reg;
`endif

  // Everything visible downstream comes from registers only.
  assign blk_ready  = !full_reg[wr_ptr_reg];
  assign coef_valid = (state_reg == STREAM);
  assign last_beat  = (cnt_reg == 6'd63);
  assign coef_last  = coef_valid && last_beat;
  assign coef_idx   = rd_addr;
  assign coef_out   = coef_valid ? bank[rd_ptr_reg][rd_addr] : '0;
  assign drop_cnt   = drop_cnt_reg;

  assign capture = blk_valid && blk_ready;
  assign xfer    = coef_valid && coef_ready;

  always_comb begin
    full_next     = full_reg;
    wr_ptr_next   = wr_ptr_reg;
    rd_ptr_next   = rd_ptr_reg;
    cnt_next      = cnt_reg;
    drop_cnt_next = drop_cnt_reg;
    if (capture) begin
      full_next[wr_ptr_reg] = 1'b1;
      wr_ptr_next           = !wr_ptr_reg;
    end else if (blk_valid && drop_cnt_reg != 16'hFFFF) begin
      drop_cnt_next = drop_cnt_reg + 16'd1;
    end
    if (xfer) begin
      if (last_beat) begin
        full_next[rd_ptr_reg] = 1'b0;
        rd_ptr_next           = !rd_ptr_reg;
        cnt_next              = 6'd0;
      end else begin
        cnt_next = cnt_reg + 6'd1;
      end
    end
    // Look ahead at the bank the reader will face next so a fresh capture streams
    // on the following cycle and back-to-back blocks leave no bubble.
    state_next = full_next[rd_ptr_next] ? STREAM : IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      full_reg     <= 2'b00;
      wr_ptr_reg   <= 1'b0;
      rd_ptr_reg   <= 1'b0;
      cnt_reg      <= 6'd0;
      drop_cnt_reg <= 16'd0;
    end else begin
      state_reg    <= state_next;
      full_reg     <= full_next;
      wr_ptr_reg   <= wr_ptr_next;
      rd_ptr_reg   <= rd_ptr_next;
      cnt_reg      <= cnt_next;
      drop_cnt_reg <= drop_cnt_next;
    end
  end

  // Coefficient storage needs no reset: a bank is only read once its full flag is set.
  always_ff @(posedge clk) begin
    if (capture) begin
      for (int i = 0; i < N_COEF; i++) begin
        bank[wr_ptr_reg][i] <= blk_word[i];
      end
    end
  end

endmodule

// File: tb/tb_dct_coef_serializer.sv
// Randomized bench for dct_coef_serializer against a queue-based beat model.
module tb_dct_coef_serializer;

  localparam int DATA_W = 16;

  logic                 clk;
  logic                 rst_n;
  logic [64*DATA_W-1:0] blk_in;
  logic                 blk_valid;
  logic                 blk_ready;
  logic [DATA_W-1:0]    coef_out;
  logic [5:0]           coef_idx;
  logic                 coef_valid;
  logic                 coef_ready;
  logic                 coef_last;
  logic [15:0]          drop_cnt;

  dct_coef_serializer #(.DATA_W(DATA_W), .N_DIM(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .blk_in     (blk_in),
    .blk_valid  (blk_valid),
    .blk_ready  (blk_ready),
    .coef_out   (coef_out),
    .coef_idx   (coef_idx),
    .coef_valid (coef_valid),
    .coef_ready (coef_ready),
    .coef_last  (coef_last),
    .drop_cnt   (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [5:0]        idx;
    logic              last;
  } beat_t;

  beat_t       exp_q[$];
  int          scan_order[64];
  int          model_drops;
  int          n_checks;
  int          n_errors;
  int          n_blocks;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference scan: walk the anti-diagonals u+v = s of the 8x8 grid, alternating direction.
  task automatic build_scan();
    int n;
    n = 0;
`ifdef DCT_SER_ZIGZAG_EN
    for (int s = 0; s <= 14; s++) begin
      int lo, hi;
      lo = (s > 7) ? s - 7 : 0;
      hi = (s < 7) ? s : 7;
      if (s % 2 == 0) begin
        for (int u = hi; u >= lo; u--) begin scan_order[n] = u*8 + (s-u); n++; end
      end else begin
        for (int u = lo; u <= hi; u++) begin scan_order[n] = u*8 + (s-u); n++; end
      end
    end
`else
    for (int k = 0; k < 64; k++) scan_order[k] = k;
`endif
  endtask

  task automatic load_ramp();
    for (int k = 0; k < 64; k++) blk_in[k*DATA_W +: DATA_W] = DATA_W'(k);
  endtask

  task automatic load_random();
    for (int k = 0; k < 64; k++) blk_in[k*DATA_W +: DATA_W] = DATA_W'($urandom);
  endtask

  // One clock: check outputs mid-cycle, advance the model for the coming edge, then step past it.
  task automatic step();
    int   blocks;
    logic exp_valid;
    beat_t b;
    @(negedge clk);
    if (!rst_n) begin
      check_val("rst_coef_valid", 32'(coef_valid), 32'd0);
      check_val("rst_coef_out", 32'(coef_out), 32'd0);
      check_val("rst_blk_ready", 32'(blk_ready), 32'd1);
      check_val("rst_drop_cnt", 32'(drop_cnt), 32'd0);
    end else begin
      exp_valid = (exp_q.size() > 0);
      blocks    = (exp_q.size() + 63) / 64;
      check_val("coef_valid", 32'(coef_valid), 32'(exp_valid));
      if (exp_valid) begin
        b = exp_q[0];
        check_val("coef_out", 32'(coef_out), 32'(b.data));
        check_val("coef_idx", 32'(coef_idx), 32'(b.idx));
        check_val("coef_last", 32'(coef_last), 32'(b.last));
      end else begin
        check_val("idle_coef_out", 32'(coef_out), 32'd0);
        check_val("idle_coef_last", 32'(coef_last), 32'd0);
      end
      check_val("blk_ready", 32'(blk_ready), 32'(blocks < 2));
      check_val("drop_cnt", 32'(drop_cnt), 32'(model_drops));
      if (exp_valid && coef_ready) begin
        b = exp_q.pop_front();
        if (b.last) $display("block done (%0d blocks so far) at %0t", ++n_blocks, $time);
      end
      if (blk_valid) begin
        if (blocks < 2) begin
          for (int j = 0; j < 64; j++) begin
            b.idx  = 6'(scan_order[j]);
            b.data = blk_in[scan_order[j]*DATA_W +: DATA_W];
            b.last = (j == 63);
            exp_q.push_back(b);
          end
          $display("block captured at %0t", $time);
        end else begin
          if (model_drops < 65535) model_drops++;
          $display("block dropped at %0t (drops=%0d)", $time, model_drops);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks    = 0;
    n_errors    = 0;
    n_blocks    = 0;
    model_drops = 0;
    build_scan();

    // Reset held with a block offered: nothing may be captured.
    rst_n      = 1'b0;
    blk_valid  = 1'b1;
    coef_ready = 1'b1;
    load_random();
    repeat (3) step();
    blk_valid = 1'b0;
    rst_n     = 1'b1;
    step();

    // Single ramp block at full throughput.
    load_ramp();
    blk_valid = 1'b1;
    step();
    blk_valid = 1'b0;
    repeat (70) step();

    // Ramp block with consumer toggling every cycle.
    load_ramp();
    blk_valid = 1'b1;
    step();
    blk_valid = 1'b0;
    for (int i = 0; i < 140; i++) begin
      coef_ready = i[0];
      step();
    end
    coef_ready = 1'b1;
    repeat (4) step();

    // Three blocks on consecutive cycles: the third must be dropped.
    for (int i = 0; i < 3; i++) begin
      load_random();
      blk_valid = 1'b1;
      step();
    end
    blk_valid = 1'b0;
    repeat (135) step();

    // Random traffic and random backpressure.
    for (int i = 0; i < 1500; i++) begin
      blk_valid  = ($urandom_range(0, 29) == 0);
      coef_ready = ($urandom_range(0, 3) != 0);
      if (blk_valid) load_random();
      step();
    end
    blk_valid  = 1'b0;
    coef_ready = 1'b1;
    repeat (200) step();

    // Reset arriving mid-block must clear outputs without waiting for a clock.
    load_ramp();
    blk_valid = 1'b1;
    step();
    blk_valid = 1'b0;
    repeat (20) step();
    #2;
    rst_n = 1'b0;
    #1;
    check_val("async_coef_valid", 32'(coef_valid), 32'd0);
    check_val("async_coef_out", 32'(coef_out), 32'd0);
    check_val("async_coef_idx", 32'(coef_idx), 32'd0);
    check_val("async_coef_last", 32'(coef_last), 32'd0);
    check_val("async_blk_ready", 32'(blk_ready), 32'd1);
    exp_q.delete();
    model_drops = 0;
    repeat (2) step();
    rst_n = 1'b1;
    step();
    load_ramp();
    blk_valid = 1'b1;
    step();
    blk_valid = 1'b0;
    repeat (70) step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
